// File: rtl/hazard_stall_unit_pkg.sv
// rtl/hazard_stall_unit_pkg.sv - shared state encoding, constants and operand-hit helper
package hazard_stall_unit_pkg;

  typedef enum logic [1:0] {
    RUN          = 2'd0,
    FREEZE       = 2'd1,
    FREEZE_FLUSH = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO      = 5'd0;
  localparam int         CNT_W_DEFAULT = 16;

  // True when a producer tag r feeds a source operand actually read in ID; x0 never hits.
  function automatic logic rs_hit(input logic [4:0] r,
                                  input logic [4:0] rs1, input logic use1,
                                  input logic [4:0] rs2, input logic use2);
    return (r != REG_ZERO) && (((r == rs1) && use1) || ((r == rs2) && use2));
  endfunction

endpackage

// File: rtl/hazard_perf_counter.sv
// rtl/hazard_perf_counter.sv - one saturating event counter
module hazard_perf_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (inc && (count != {W{1'b1}}))
      count <= count + W'(1);
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use/branch interlock, redirect flush and memory-wait freeze
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_useRs1,
  input  logic             ID_useRs2,
  input  logic             ID_isBranch,
  input  logic [4:0]       EX_rd,
  input  logic             EX_writeToReg,
  input  logic             EX_memRead,
  input  logic [4:0]       MEM_rd,
  input  logic             MEM_memRead,
  input  logic             EX_redirect,
  input  logic             MEM_busy,
  output logic             PC_write,
  output logic             IFID_write,
  output logic             IFID_flush,
  output logic             IDEX_bubble,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] perf_loadUse,
  output logic [CNT_W-1:0] perf_brStall,
  output logic [CNT_W-1:0] perf_flush
);

  state_t state, next_state;
  logic   ex_hit, mem_hit, load_use, br_haz, stall, run_eval;

  assign ex_hit   = rs_hit(EX_rd,  ID_rs1, ID_useRs1, ID_rs2, ID_useRs2);
  assign mem_hit  = rs_hit(MEM_rd, ID_rs1, ID_useRs1, ID_rs2, ID_useRs2);
  assign load_use = EX_memRead && EX_writeToReg && ex_hit;
  assign br_haz   = ID_isBranch && ((EX_writeToReg && ex_hit) || (MEM_memRead && mem_hit));
  assign stall    = load_use || br_haz;

  always_comb begin
    PC_write    = 1'b1;
    IFID_write  = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_bubble = 1'b0;
    pipe_freeze = 1'b0;
    run_eval    = 1'b0;
    next_state  = state;
    if (RST) begin
      PC_write    = 1'b0;
      IFID_write  = 1'b0;
      IFID_flush  = 1'b1;
      IDEX_bubble = 1'b1;
      next_state  = RUN;
    end else if (MEM_busy && (state != RUN || MEM_busy)) begin
      // Any state freezes while memory holds; a redirect seen now is remembered.
      PC_write    = 1'b0;
      IFID_write  = 1'b0;
      pipe_freeze = 1'b1;
      if (EX_redirect || state == FREEZE_FLUSH)
        next_state = FREEZE_FLUSH;
      else
        next_state = FREEZE;
    end else if (state == FREEZE_FLUSH) begin
      // IF/ID is written with a NOP, so its enable stays high during a flush.
      IFID_flush  = 1'b1;
      IDEX_bubble = 1'b1;
      next_state  = RUN;
    end else begin
      run_eval   = 1'b1;
      next_state = RUN;
      if (EX_redirect) begin
        IFID_flush  = 1'b1;
        IDEX_bubble = 1'b1;
      end else if (stall) begin
        PC_write    = 1'b0;
        IFID_write  = 1'b0;
        IDEX_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      state <= RUN;
    else
      state <= next_state;
  end

`ifdef HAZARD_PERF_EN
  hazard_perf_counter #(.W(CNT_W)) u_cnt_load_use (
    .clk(CLK), .rst(RST), .inc(run_eval && load_use && !EX_redirect), .count(perf_loadUse)
  );
  hazard_perf_counter #(.W(CNT_W)) u_cnt_br_stall (
    .clk(CLK), .rst(RST), .inc(run_eval && br_haz && !load_use && !EX_redirect),
    .count(perf_brStall)
  );
  hazard_perf_counter #(.W(CNT_W)) u_cnt_flush (
    .clk(CLK), .rst(RST), .inc(IFID_flush && !RST), .count(perf_flush)
  );
`else
  assign perf_loadUse = '0;
  assign perf_brStall = '0;
  assign perf_flush   = '0;
  logic unused_run_eval;
  assign unused_run_eval = run_eval;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - scoreboard bench with directed pipeline scenarios and random traffic
module tb_hazard_stall_unit;

  localparam int CNT_W = 16;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [4:0] ID_rs1 = '0, ID_rs2 = '0, EX_rd = '0, MEM_rd = '0;
  logic ID_useRs1 = 0, ID_useRs2 = 0, ID_isBranch = 0, EX_writeToReg = 0, EX_memRead = 0;
  logic MEM_memRead = 0, EX_redirect = 0, MEM_busy = 0;
  logic PC_write, IFID_write, IFID_flush, IDEX_bubble, pipe_freeze;
  logic [CNT_W-1:0] perf_loadUse, perf_brStall, perf_flush;

  hazard_stall_unit #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_useRs1(ID_useRs1),
    .ID_useRs2(ID_useRs2), .ID_isBranch(ID_isBranch), .EX_rd(EX_rd),
    .EX_writeToReg(EX_writeToReg), .EX_memRead(EX_memRead), .MEM_rd(MEM_rd),
    .MEM_memRead(MEM_memRead), .EX_redirect(EX_redirect), .MEM_busy(MEM_busy),
    .PC_write(PC_write), .IFID_write(IFID_write), .IFID_flush(IFID_flush),
    .IDEX_bubble(IDEX_bubble), .pipe_freeze(pipe_freeze), .perf_loadUse(perf_loadUse),
    .perf_brStall(perf_brStall), .perf_flush(perf_flush)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic rst;
    logic [4:0] rs1, rs2;
    logic u1, u2, br;
    logic [4:0] exrd;
    logic exw, exm;
    logic [4:0] memrd;
    logic memm, redir, busy;
  } stim_t;

  typedef struct packed {
    logic [4:0] ctl;  // {PC_write, IFID_write, IFID_flush, IDEX_bubble, pipe_freeze}
    logic [CNT_W-1:0] lu, bs, fl;
  } exp_t;

  exp_t sb[$];
  int compared = 0, mismatched = 0;

  // Model state: only whether a redirect is waiting behind a memory hold, plus event totals.
  bit pending = 0;
  int n_lu = 0, n_bs = 0, n_fl = 0;

  function automatic stim_t mk(int rs1, int rs2, bit u1, bit u2, bit br, int exrd, bit exw,
                               bit exm, int memrd, bit memm, bit redir, bit busy, bit rst);
    stim_t s;
    s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.u1 = u1; s.u2 = u2; s.br = br;
    s.exrd = 5'(exrd); s.exw = exw; s.exm = exm; s.memrd = 5'(memrd); s.memm = memm;
    s.redir = redir; s.busy = busy; s.rst = rst;
    return s;
  endfunction

  function automatic bit reads(input stim_t s, input logic [4:0] r);
    return (r != 0) && ((s.u1 && s.rs1 == r) || (s.u2 && s.rs2 == r));
  endfunction

  function automatic logic [CNT_W-1:0] sat(input int n);
    return (n >= (1 << CNT_W) - 1) ? {CNT_W{1'b1}} : CNT_W'(n);
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    bit lu, bh, ev;
    @(posedge CLK); #1;
    RST = s.rst; ID_rs1 = s.rs1; ID_rs2 = s.rs2; ID_useRs1 = s.u1; ID_useRs2 = s.u2;
    ID_isBranch = s.br; EX_rd = s.exrd; EX_writeToReg = s.exw; EX_memRead = s.exm;
    MEM_rd = s.memrd; MEM_memRead = s.memm; EX_redirect = s.redir; MEM_busy = s.busy;
    lu = s.exm && s.exw && reads(s, s.exrd);
    bh = s.br && ((s.exw && reads(s, s.exrd)) || (s.memm && reads(s, s.memrd)));
    ev = 0;
    if (s.rst) begin
      e.ctl = 5'b00110;
      pending = 0; n_lu = 0; n_bs = 0; n_fl = 0;
    end else if (s.busy) begin
      e.ctl = 5'b00001;
      if (s.redir) pending = 1;
    end else if (pending) begin
      e.ctl = 5'b11110;
      pending = 0;
    end else begin
      ev = 1;
      if (s.redir)        e.ctl = 5'b11110;
      else if (lu || bh)  e.ctl = 5'b00010;
      else                e.ctl = 5'b11000;
    end
`ifdef HAZARD_PERF_EN
    e.lu = sat(n_lu); e.bs = sat(n_bs); e.fl = sat(n_fl);
    if (ev && lu && !s.redir) n_lu++;
    if (ev && bh && !lu && !s.redir) n_bs++;
    if (!s.rst && e.ctl[2]) n_fl++;
`else
    e.lu = '0; e.bs = '0; e.fl = '0;
    if (ev) n_lu = n_lu + 0;
`endif
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ctl{pcw,ifw,flush,bubble,freeze}", CNT_W'({PC_write, IFID_write, IFID_flush,
            IDEX_bubble, pipe_freeze}), CNT_W'(e.ctl));
        chk("perf_loadUse", perf_loadUse, e.lu);
        chk("perf_brStall", perf_brStall, e.bs);
        chk("perf_flush", perf_flush, e.fl);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    stim_t s;
    // reset
    apply(mk(0,0,0,0,0, 0,0,0, 0,0, 0,0,1));
    apply(mk(0,0,0,0,0, 0,0,0, 0,0, 0,0,1));
    apply(mk(0,0,0,0,0, 0,0,0, 0,0, 0,0,0));
    // lw x5 in EX, add x6,x5,x1 in ID, then bubble advances the load
    apply(mk(5,1,1,1,0, 5,1,1, 0,0, 0,0,0));
    apply(mk(5,1,1,1,0, 0,0,0, 5,1, 0,0,0));
    // lw x5 in EX, beq x5,x0 in ID: EX term then MEM term
    apply(mk(5,0,1,1,1, 5,1,1, 0,0, 0,0,0));
    apply(mk(5,0,1,1,1, 0,0,0, 5,1, 0,0,0));
    apply(mk(5,0,1,1,1, 0,0,0, 0,0, 0,0,0));
    // branch after ALU producer
    apply(mk(3,4,1,1,1, 4,1,0, 0,0, 0,0,0));
    apply(mk(3,4,1,1,1, 0,0,0, 4,0, 0,0,0));
    // redirect coincident with load-use
    apply(mk(5,1,1,1,0, 5,1,1, 0,0, 1,0,0));
    // memory hold with redirect on the first cycle, flush on release
    apply(mk(0,0,0,0,0, 0,0,0, 0,0, 1,1,0));
    apply(mk(0,0,0,0,0, 0,0,0, 0,0, 0,1,0));
    apply(mk(0,0,0,0,0, 0,0,0, 0,0, 0,1,0));
    apply(mk(5,1,1,1,0, 5,1,1, 0,0, 0,0,0));
    apply(mk(0,0,0,0,0, 0,0,0, 0,0, 0,0,0));
    // plain hold releasing into a load-use stall
    apply(mk(5,1,1,1,0, 5,1,1, 0,0, 0,1,0));
    apply(mk(5,1,1,1,0, 5,1,1, 0,0, 0,0,0));
    // x0 never hazards; unused rs2 never hazards
    apply(mk(0,0,1,1,1, 0,1,1, 0,1, 0,0,0));
    apply(mk(1,7,1,0,1, 7,1,1, 7,1, 0,0,0));
    // reset during pending flush discards it
    apply(mk(0,0,0,0,0, 0,0,0, 0,0, 1,1,0));
    apply(mk(0,0,0,0,0, 0,0,0, 0,0, 0,1,0));
    apply(mk(0,0,0,0,0, 0,0,0, 0,0, 0,1,1));
    apply(mk(0,0,0,0,0, 0,0,0, 0,0, 0,0,0));
    apply(mk(0,0,0,0,0, 0,0,0, 0,0, 0,0,0));
    // random traffic over a small register window so hits are frequent
    for (int i = 0; i < 3000; i++) begin
      s = mk($urandom_range(0,3), $urandom_range(0,3), 1'($urandom), 1'($urandom),
             1'($urandom), $urandom_range(0,3), 1'($urandom), 1'($urandom),
             $urandom_range(0,3), 1'($urandom), ($urandom_range(0,7) == 0),
             ($urandom_range(0,4) == 0), ($urandom_range(0,150) == 0));
      apply(s);
    end
    @(posedge CLK);
    @(negedge CLK); #1;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: actual=%0d left required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
